// File: rtl/hcsr04_echo_emulator.sv
// hcsr04_echo_emulator: sensor end of the HC-SR04 trigger/echo protocol.
// Define ECHO_JITTER_EN to add 0..15 cycles of LFSR jitter to non-timeout echoes.
module hcsr04_echo_emulator #(
   parameter int CYCLES_PER_MM  = 294,
   parameter int MIN_TRIG       = 500,
   parameter int ECHO_DELAY     = 10000,
   parameter int MAX_MM         = 4000,
   parameter int TIMEOUT_CYCLES = 1900000,
   parameter int HOLDOFF        = 5000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trigger,
   input  logic [15:0] distance_mm,
   output logic        echo,
   output logic        busy,
   output logic        trig_err
);
   typedef enum logic [2:0] {IDLE, TRIG, DELAY, ECHO, HOLD} state_t;
   state_t state, state_n;
   logic [1:0] sync;
   logic trig_s, trig_d, busy_n, err_n, timeout;
   logic [23:0] cnt, cnt_n, width, width_n, base_w, new_w;
   assign trig_s = sync[1];
   assign timeout = distance_mm == 16'd0 || 32'(distance_mm) > 32'(MAX_MM);
   assign base_w = timeout ? 24'(TIMEOUT_CYCLES) : 24'(32'(distance_mm) * 32'(CYCLES_PER_MM));
`ifdef ECHO_JITTER_EN
   logic [7:0] lfsr;
   logic accept;
   assign accept = state == TRIG && !trig_s && cnt >= 24'(MIN_TRIG);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lfsr <= 8'hA5;
      else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign new_w = timeout ? base_w : base_w + 24'(lfsr[3:0]);
`else
   assign new_w = base_w;
`endif
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      width_n = width;
      busy_n = busy;
      err_n = 1'b0;
      case (state)
         IDLE:
            if (trig_s && !trig_d) begin
               state_n = TRIG;
               cnt_n = 24'd1;
            end
         TRIG:
            if (!trig_s) begin
               if (cnt >= 24'(MIN_TRIG)) begin
                  state_n = DELAY;
                  cnt_n = 24'd1;
                  width_n = new_w;
                  busy_n = 1'b1;
               end else begin
                  state_n = IDLE;
                  err_n = 1'b1;
               end
            end else if (cnt < 24'(MIN_TRIG)) cnt_n = cnt + 24'd1;
         DELAY:
            if (cnt >= 24'(ECHO_DELAY - 1)) begin
               state_n = ECHO;
               cnt_n = 24'd1;
            end else cnt_n = cnt + 24'd1;
         ECHO:
            if (cnt >= width) begin
               state_n = HOLD;
               cnt_n = 24'd1;
            end else cnt_n = cnt + 24'd1;
         HOLD:
            // a trigger still high here must fall before a new rise can be seen in IDLE
            if (cnt < 24'(HOLDOFF)) cnt_n = cnt + 24'd1;
            else if (!trig_s) begin
               state_n = IDLE;
               busy_n = 1'b0;
               cnt_n = 24'd0;
            end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync <= 2'b00;
         trig_d <= 1'b0;
         state <= IDLE;
         cnt <= 24'd0;
         width <= 24'd0;
         busy <= 1'b0;
         echo <= 1'b0;
         trig_err <= 1'b0;
      end else begin
         sync <= {sync[0], trigger};
         trig_d <= trig_s;
         state <= state_n;
         cnt <= cnt_n;
         width <= width_n;
         busy <= busy_n;
         echo <= state_n == ECHO;
         trig_err <= err_n;
      end
endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// tb_hcsr04_echo_emulator: directed and random trigger transactions against a timing model
module tb_hcsr04_echo_emulator;
   localparam int CPM = 3, MIN = 20, ED = 50, MAXMM = 400, TMO = 1500, HO = 40;
   localparam int LIM = ED + TMO + HO + 300;
   logic clk = 0, rst_n = 0, trigger = 0;
   logic [15:0] distance_mm = 0;
   logic echo, busy, trig_err;
   int cyc = 0, n_chk = 0, n_fail = 0, fall_cyc = 0;
   int n_rise = 0, n_efall = 0, n_brise = 0, n_bfall = 0, n_err = 0;
   int rise_cyc = 0, efall_cyc = 0, brise_cyc = 0, bfall_cyc = 0;
   logic echo_p = 0, busy_p = 0;
   hcsr04_echo_emulator #(.CYCLES_PER_MM(CPM), .MIN_TRIG(MIN), .ECHO_DELAY(ED),
      .MAX_MM(MAXMM), .TIMEOUT_CYCLES(TMO), .HOLDOFF(HO)) dut (
      .clk(clk), .rst_n(rst_n), .trigger(trigger), .distance_mm(distance_mm),
      .echo(echo), .busy(busy), .trig_err(trig_err));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (echo && !echo_p) begin n_rise++; rise_cyc = cyc; end
      if (!echo && echo_p) begin n_efall++; efall_cyc = cyc; end
      if (busy && !busy_p) begin n_brise++; brise_cyc = cyc; end
      if (!busy && busy_p) begin n_bfall++; bfall_cyc = cyc; end
      if (trig_err) n_err++;
      echo_p = echo;
      busy_p = busy;
   end
   function automatic int exp_w(input int mm);
      return (mm == 0 || mm > MAXMM) ? TMO : mm * CPM;
   endfunction
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic check_w(input string tag, input int w, input int mm);
`ifdef ECHO_JITTER_EN
      int j = (mm == 0 || mm > MAXMM) ? 0 : 15;
      check({tag, "_in_range"}, int'(w >= exp_w(mm) && w <= exp_w(mm) + j), 1);
`else
      check(tag, w, exp_w(mm));
`endif
   endtask
   task automatic pulse(input int n, input int mm);
      @(posedge clk);
      #1 trigger = 1;
      distance_mm = 16'(mm);
      repeat (n) @(posedge clk);
      #1 trigger = 0;
      fall_cyc = cyc;
   endtask
   task automatic txn(input int n, input int mm);
      int r0 = n_rise, e0 = n_err, b0 = n_bfall, br0 = n_brise;
      pulse(n, mm);
      if (n >= MIN) begin
         for (int i = 0; i < LIM && n_bfall == b0; i++) @(posedge clk);
         check("busy_done", n_bfall - b0, 1);
         check("echo_count", n_rise - r0, 1);
         check("echo_latency", rise_cyc - fall_cyc, ED + 2);
         check_w("echo_width", efall_cyc - rise_cyc, mm);
         check("busy_rise", brise_cyc - fall_cyc, 3);
         check("holdoff", bfall_cyc - efall_cyc, HO);
         check("no_err", n_err - e0, 0);
      end else begin
         repeat (10) @(posedge clk);
         check("err_pulse", n_err - e0, 1);
         check("err_no_echo", n_rise - r0, 0);
         check("err_no_busy", n_brise - br0, 0);
      end
      repeat ($urandom_range(1, 5)) @(posedge clk);
   endtask
   initial begin
      int r0, e0, f0, b0, t0, mm;
      repeat (3) @(posedge clk);
      #1 check("rst_echo", int'(echo), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err", int'(trig_err), 0);
      rst_n = 1;
      repeat (3) @(posedge clk);
      txn(MIN, 100);
      txn(MIN, 50);
      txn(MIN + 7, 100);
      txn(MIN - 1, 100);
      txn(5, 100);
      txn(MIN, 0);
      txn(MIN, 5000);
      txn(MIN, MAXMM);
      txn(MIN, MAXMM + 1);
      r0 = n_rise; e0 = n_err; f0 = n_efall;
      pulse(MIN + 5, 100);
      for (int i = 0; i < LIM && n_rise == r0; i++) @(posedge clk);
      repeat (10) @(posedge clk);
      pulse(MIN + 5, 7);
      for (int i = 0; i < LIM && n_efall == f0; i++) @(posedge clk);
      check_w("mid_echo_width", efall_cyc - rise_cyc, 100);
      #1 trigger = 1;
      b0 = n_bfall;
      repeat (HO + 20) @(posedge clk);
      #1 check("held_busy", int'(busy), 1);
      trigger = 0;
      t0 = cyc;
      for (int i = 0; i < LIM && n_bfall == b0; i++) @(posedge clk);
      check("held_release", bfall_cyc - t0, 3);
      repeat (60) @(posedge clk);
      check("held_no_echo", n_rise - r0, 1);
      check("held_no_err", n_err - e0, 0);
      r0 = n_rise;
      pulse(MIN, 100);
      for (int i = 0; i < LIM && n_rise == r0; i++) @(posedge clk);
      repeat (20) @(posedge clk);
      #1 rst_n = 0;
      #1 check("rst_mid_echo", int'(echo), 0);
      check("rst_mid_busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      repeat (3) @(posedge clk);
      txn(MIN, 100);
      for (int k = 0; k < 12; k++) begin
         case ($urandom_range(0, 5))
            0: mm = 0;
            1: mm = MAXMM;
            2: mm = MAXMM + 1;
            3: mm = int'($urandom_range(MAXMM + 2, 65535));
            default: mm = int'($urandom_range(1, MAXMM));
         endcase
         txn(int'($urandom_range(MIN - 4, MIN + 15)), mm);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
